// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: stochastic-to-binary converter counting ones over a STREAM_LEN-bit window with a valid/ack handshake
//  Ports: clk, rst_n (synchronous, active-high clear), start, bit_in, bit_valid,
//         busy (high in RUN), result (ones count), result_valid, result_ack.
//  Optional build macro SC_DECODE_BIPOLAR_EN: result becomes signed WIDTH+2 bits, 2*ones - STREAM_LEN.
module sc_stream_decoder #(
  parameter int WIDTH      = 8,
  parameter int STREAM_LEN = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            busy,
`ifdef SC_DECODE_BIPOLAR_EN
  output logic [WIDTH+1:0] result,
`else
  output logic [WIDTH:0]   result,
`endif
  output logic            result_valid,
  input  logic            result_ack
);
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int RW = WIDTH + 2;
`else
  localparam int RW = WIDTH + 1;
`endif
  localparam int CW = $clog2(STREAM_LEN) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [WIDTH:0]  ones_q, ones_d, ones_inc;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [RW-1:0]   result_q, result_d, enc;
  logic            valid_q, valid_d;
  assign ones_inc = ones_q + {{WIDTH{1'b0}}, bit_in};
`ifdef SC_DECODE_BIPOLAR_EN
  assign enc = {ones_inc, 1'b0} - RW'(STREAM_LEN);
`else
  assign enc = ones_inc;
`endif
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    bcnt_d   = bcnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        ones_d  = '0;
        bcnt_d  = '0;
      end
      RUN: if (bit_valid) begin
        ones_d = ones_inc;
        bcnt_d = bcnt_q + 1'b1;
        // last bit of the window: publish the count including this bit
        if (bcnt_q == CW'(STREAM_LEN - 1)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = enc;
        end
      end
      DONE: if (result_ack) begin
        valid_d = 1'b0;
        state_d = start ? RUN : IDLE;
        ones_d  = start ? '0 : ones_q;
        bcnt_d  = start ? '0 : bcnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      bcnt_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      bcnt_q   <= bcnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end
  assign busy         = state_q == RUN;
  assign result       = result_q;
  assign result_valid = valid_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: directed bench with a transaction-level model checked every cycle
module tb_sc_stream_decoder;
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int RW = 10;
  localparam logic [RW-1:0] E_ONES = RW'(256);
  localparam logic [RW-1:0] E_ALT  = RW'(0);
  localparam logic [RW-1:0] E_ZERO = RW'(-256);
`else
  localparam int RW = 9;
  localparam logic [RW-1:0] E_ONES = RW'(256);
  localparam logic [RW-1:0] E_ALT  = RW'(128);
  localparam logic [RW-1:0] E_ZERO = RW'(0);
`endif
  logic clk = 0, rst_n = 1, start = 0, bit_in = 0, bit_valid = 0, result_ack = 0;
  logic busy, result_valid;
  logic [RW-1:0] result;
  logic m_busy = 0, m_valid = 0, chk = 0;
  logic [RW-1:0] m_result = '0;
  logic pat [256];
  int tests = 0, fails = 0;
  int lat, bcyc, dec;
  logic [7:0] lfsr;

  sc_stream_decoder #(.WIDTH(8), .STREAM_LEN(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .result(result), .result_valid(result_valid), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("result_valid", 32'(result_valid), 32'(m_valid));
    check("result", 32'(result), 32'(m_result));
  end

  function automatic logic [RW-1:0] enc(input int ones);
`ifdef SC_DECODE_BIPOLAR_EN
    return RW'(2 * ones - 256);
`else
    return RW'(ones);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one conversion: start (optionally together with ack from DONE), then stream pat[] with stalls
  task automatic run_conv(input bit via_ack, input int stall_mod, input int abort_at,
                          output int l, output int bc);
    int n, ones;
    start = 1; result_ack = via_ack; bit_valid = 0;
    tick;
    l = 1; m_busy = 1; m_valid = 0;
    start = 0; result_ack = 0;
    n = 0; ones = 0; bc = 0;
    while (n < 256) begin
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1; bit_valid = 0; start = 0;
        tick;
        m_busy = 0; m_valid = 0; m_result = '0;
        rst_n = 0;
        return;
      end
      bit_valid = (bc % stall_mod) == stall_mod - 1;
      bit_in = bit_valid ? pat[n] : 1'b1;
      start = (bc == 10);
      tick;
      l++; bc++;
      if (bit_valid) begin ones += int'(pat[n]); n++; end
      if (n == 256) begin m_busy = 0; m_valid = 1; m_result = enc(ones); end
    end
    bit_valid = 0; start = 0; bit_in = 0;
  endtask

  task automatic ack_only;
    result_ack = 1;
    tick;
    m_valid = 0;
    result_ack = 0;
  endtask

  initial begin
    tick;
    chk = 1;
    tick;
    rst_n = 0;
    // T1: reset mid-run after 100 bits
    for (int i = 0; i < 256; i++) pat[i] = 1'b1;
    run_conv(0, 1, 100, lat, bcyc);
    check("t1_busy_after_rst", 32'(busy), 32'd0);
    check("t1_result_after_rst", 32'(result), 32'd0);
    // ack and bits outside RUN are ignored
    result_ack = 1; bit_valid = 1; bit_in = 1;
    repeat (3) tick;
    result_ack = 0; bit_valid = 0;
    // T2: all ones, no stalls
    run_conv(0, 1, 0, lat, bcyc);
    check("t2_latency", 32'(lat), 32'd257);
    check("t2_result", 32'(result), 32'(E_ONES));
    check("t2_model_pin", 32'(m_result), 32'(E_ONES));
    // T5: hold without ack, start pulses ignored
    for (int i = 0; i < 50; i++) begin
      start = i[0];
      tick;
    end
    start = 0;
    check("t5_held", 32'(result), 32'(E_ONES));
    // T3: alternating 1010... started back-to-back with ack+start
    for (int i = 0; i < 256; i++) pat[i] = ~i[0];
    run_conv(1, 1, 0, lat, bcyc);
    check("t3_alt_result", 32'(result), 32'(E_ALT));
    check("t3_alt_model_pin", 32'(m_result), 32'(E_ALT));
    ack_only;
    check("ack_keeps_result", 32'(result), 32'(E_ALT));
    repeat (2) tick;
    // T3: all zeros
    for (int i = 0; i < 256; i++) pat[i] = 1'b0;
    run_conv(0, 1, 0, lat, bcyc);
    check("t3_zero_result", 32'(result), 32'(E_ZERO));
    ack_only;
    // T4: valid one cycle in four, all ones
    for (int i = 0; i < 256; i++) pat[i] = 1'b1;
    run_conv(0, 4, 0, lat, bcyc);
    check("t4_stream_cycles", 32'(bcyc), 32'd1024);
    check("t4_result", 32'(result), 32'(E_ONES));
    ack_only;
    // T6: LFSR comparator stream for value 0x40
    lfsr = 8'h01;
    for (int i = 0; i < 256; i++) begin
      pat[i] = lfsr < 8'h40;
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
    end
    run_conv(0, 1, 0, lat, bcyc);
`ifdef SC_DECODE_BIPOLAR_EN
    dec = ($signed(result) + 256) / 2;
`else
    dec = int'(result);
`endif
    check("t6_within_8_of_64", 32'(dec >= 56 && dec <= 72), 32'd1);
    ack_only;
    tick;
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
